pll_cfg_seq: RTL and testbench

- Multi-channel PLL configuration and power-up sequencer. It replaces the fixed single-PLL SPI config path with one that has a parametrised channel count, trim width and timing.
- An oversampled SPI slave writes a per-channel register file.
- A per-channel state machine applies the charge-pump (CP) and VCO enables in order, with programmable delays, and reports a ready status.
- It sits between the SPI pads and the level shifters that feed the avsdpll_1v8 instances.

---
 rtl/pll_cfg_seq.sv | 321 ++++++++++++++++++++++++++++++++
 tb/tb_pll_cfg_seq.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_cfg_seq.sv
// -----------------------------------------------------------------------------
// pll_cfg_seq
//
// Multi-channel PLL configuration and power-up sequencer. An oversampled SPI
// slave writes a small per-channel register file. A per-channel state machine
// then walks each PLL through OFF -> CP_ON -> VCO_ON -> READY. The CP-to-VCO
// delay is programmable and the VCO settle time is fixed by a parameter.
//
// Ports:
//   ref_clk      system clock, all logic on its rising edge
//   porb         synchronous active-low reset
//   spi_sck      SPI clock (asynchronous, synchronised here)
//   spi_csb      SPI chip select, active-low (asynchronous)
//   spi_sdi      SPI data in (asynchronous)
//   spi_sdo      SPI data out
//   spi_sdo_oe   SDO output enable, high only during a read data phase
//   pll_cp_enb   per-channel charge-pump enable, active-low
//   pll_vco_enb  per-channel VCO enable, active-low
//   pll_bypass   per-channel bypass
//   pll_trim     applied trim, channel c at [c*TRIM_W +: TRIM_W]
//   pll_ready    per-channel sequence complete
//
// Frame: 16 bits, MSB first, SPI mode 0. bit15 = R/W (1 = write),
// bits14:8 = address, bits7:0 = data. Register map per channel c
// (base = c*4): CTRL, TRIM, DLY, STATUS(RO). Address 0x7F = ID(RO).
// -----------------------------------------------------------------------------
module pll_cfg_seq #(
    parameter int         N_PLL  = 2,
    parameter int         TRIM_W = 4,
    parameter int         SETTLE = 64,
    parameter logic [7:0] ID_VAL = 8'hA5
) (
    input  logic                      ref_clk,
    input  logic                      porb,
    input  logic                      spi_sck,
    input  logic                      spi_csb,
    input  logic                      spi_sdi,
    output logic                      spi_sdo,
    output logic                      spi_sdo_oe,
    output logic [N_PLL-1:0]          pll_cp_enb,
    output logic [N_PLL-1:0]          pll_vco_enb,
    output logic [N_PLL-1:0]          pll_bypass,
    output logic [N_PLL*TRIM_W-1:0]   pll_trim,
    output logic [N_PLL-1:0]          pll_ready
);

    // Counter must hold both an 8-bit DLY value and SETTLE-1.
    localparam int CNT_W = ($clog2(SETTLE) > 8) ? $clog2(SETTLE) : 8;
    localparam logic [CNT_W-1:0] SETTLE_M1 = CNT_W'(SETTLE - 1);

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_CP_ON  = 2'd1,
        ST_VCO_ON = 2'd2,
        ST_READY  = 2'd3
    } seq_state_e;

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    // Synchroniser stages, bit order {sdi, csb, sck}.
    logic [2:0]        sync1_q, sync1_d;
    logic [2:0]        sync2_q, sync2_d;
    logic              sck_prev_q, sck_prev_d;

    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic [15:0]       shift_in_q, shift_in_d;
    logic              wr_pend_q, wr_pend_d;
    logic              rd_pend_q, rd_pend_d;
    logic              rd_frame_q, rd_frame_d;
    logic [7:0]        shift_out_q, shift_out_d;
    logic              sdo_q, sdo_d;
    logic              sdo_oe_q, sdo_oe_d;

    logic [1:0]        ctrl_q     [N_PLL];
    logic [1:0]        ctrl_d     [N_PLL];
    logic [TRIM_W-1:0] trim_reg_q [N_PLL];
    logic [TRIM_W-1:0] trim_reg_d [N_PLL];
    logic [7:0]        dly_q      [N_PLL];
    logic [7:0]        dly_d      [N_PLL];

    seq_state_e        state_q    [N_PLL];
    seq_state_e        state_d    [N_PLL];
    logic [CNT_W-1:0]  cnt_q      [N_PLL];
    logic [CNT_W-1:0]  cnt_d      [N_PLL];
    logic [TRIM_W-1:0] trim_q     [N_PLL];
    logic [TRIM_W-1:0] trim_d     [N_PLL];
    logic [N_PLL-1:0]  bypass_q, bypass_d;

    // ---------------------------------------------------------------------
    // Synchronised SPI view
    // ---------------------------------------------------------------------
    logic sck_s, csb_s, sdi_s;
    logic sck_rise, sck_fall;

    assign sck_s    = sync2_q[0];
    assign csb_s    = sync2_q[1];
    assign sdi_s    = sync2_q[2];
    assign sck_rise =  sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s &  sck_prev_q;

    // ---------------------------------------------------------------------
    // Read mux: address taken from the first 8 bits of the frame
    // ---------------------------------------------------------------------
    logic [6:0] rd_addr;
    logic [7:0] rd_data;

    assign rd_addr = shift_in_q[6:0];

    always_comb begin
        // NOTE: every combinational output gets a default first so that no
        // path through the block leaves it unassigned and infers a latch.
        rd_data = 8'h00;
        if (rd_addr == 7'h7F) begin
            rd_data = ID_VAL;
        end else begin
            for (int c = 0; c < N_PLL; c++) begin
                if (rd_addr[6:2] == 5'(c)) begin
                    case (rd_addr[1:0])
                        2'd0:    rd_data = {6'd0, ctrl_q[c]};
                        2'd1:    rd_data = 8'(trim_reg_q[c]);
                        2'd2:    rd_data = dly_q[c];
                        default: rd_data = {5'd0, (state_q[c] == ST_READY), state_q[c]};
                    endcase
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // SPI slave: bit counter, shift-in, shift-out
    // ---------------------------------------------------------------------
    always_comb begin
        sync1_d     = {spi_sdi, spi_csb, spi_sck};
        sync2_d     = sync1_q;
        sck_prev_d  = sck_s;
        bit_cnt_d   = bit_cnt_q;
        shift_in_d  = shift_in_q;
        wr_pend_d   = 1'b0;
        rd_pend_d   = 1'b0;
        rd_frame_d  = rd_frame_q;
        shift_out_d = shift_out_q;
        sdo_d       = sdo_q;
        sdo_oe_d    = sdo_oe_q;

        if (csb_s) begin
            bit_cnt_d  = 5'd0;
            rd_frame_d = 1'b0;
            sdo_d      = 1'b0;
            sdo_oe_d   = 1'b0;
        end else begin
            // The counter saturates at 16, so rises past the 16th are dropped
            // and the committed frame is always the first 16 bits.
            if (sck_rise && (bit_cnt_q != 5'd16)) begin
                shift_in_d = {shift_in_q[14:0], sdi_s};
                bit_cnt_d  = bit_cnt_q + 5'd1;
                if (bit_cnt_q == 5'd15) begin
                    wr_pend_d = 1'b1;
                end
                // R/W sits at bit 6 once seven bits have arrived.
                if ((bit_cnt_q == 5'd7) && !shift_in_q[6]) begin
                    rd_pend_d = 1'b1;
                end
            end

            if (rd_pend_q) begin
                shift_out_d = rd_data;
                rd_frame_d  = 1'b1;
            end else if (sck_fall && rd_frame_q) begin
                // Zeros shift in behind the data, so SDO holds 0 after bit 0.
                sdo_oe_d    = 1'b1;
                sdo_d       = shift_out_q[7];
                shift_out_d = {shift_out_q[6:0], 1'b0};
            end
        end
    end

    // ---------------------------------------------------------------------
    // Register file writes, one cycle after the 16th rise
    // ---------------------------------------------------------------------
    logic [6:0] wr_addr;
    logic [7:0] wr_data;

    assign wr_addr = shift_in_q[14:8];
    assign wr_data = shift_in_q[7:0];

    always_comb begin
        ctrl_d     = ctrl_q;
        trim_reg_d = trim_reg_q;
        dly_d      = dly_q;
        if (wr_pend_q && shift_in_q[15]) begin
            for (int c = 0; c < N_PLL; c++) begin
                if (wr_addr[6:2] == 5'(c)) begin
                    case (wr_addr[1:0])
                        2'd0:    ctrl_d[c]     = wr_data[1:0];
                        2'd1:    trim_reg_d[c] = wr_data[TRIM_W-1:0];
                        2'd2:    dly_d[c]      = wr_data;
                        default: ;  // STATUS is read-only
                    endcase
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Per-channel power-up sequencers
    // ---------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        trim_d   = trim_q;
        bypass_d = bypass_q;
        for (int c = 0; c < N_PLL; c++) begin
            bypass_d[c] = ctrl_q[c][1];

            // Trim is only applied to the analog block while the PLL is off;
            // writes made while active wait here until the channel drops out.
            if (state_q[c] == ST_OFF) begin
                trim_d[c] = trim_reg_q[c];
            end

            // Dropping en_req wins over any counter expiry.
            if (!ctrl_q[c][0]) begin
                state_d[c] = ST_OFF;
                cnt_d[c]   = '0;
            end else begin
                case (state_q[c])
                    ST_OFF: begin
                        state_d[c] = ST_CP_ON;
                        cnt_d[c]   = CNT_W'(dly_q[c]);
                    end
                    ST_CP_ON: begin
                        if (cnt_q[c] == '0) begin
                            state_d[c] = ST_VCO_ON;
                            cnt_d[c]   = SETTLE_M1;
                        end else begin
                            cnt_d[c] = cnt_q[c] - CNT_W'(1);
                        end
                    end
                    ST_VCO_ON: begin
                        if (cnt_q[c] == '0) begin
                            state_d[c] = ST_READY;
                        end else begin
                            cnt_d[c] = cnt_q[c] - CNT_W'(1);
                        end
                    end
                    default: ;  // ST_READY holds until en_req drops
                endcase
            end
        end
    end

    // Enables decode straight from the state register: both rise together on
    // entry to OFF, and VCO can only be enabled in states that follow CP_ON.
    always_comb begin
        pll_cp_enb  = '1;
        pll_vco_enb = '1;
        pll_ready   = '0;
        pll_trim    = '0;
        for (int c = 0; c < N_PLL; c++) begin
            pll_cp_enb[c]  = (state_q[c] == ST_OFF);
            pll_vco_enb[c] = (state_q[c] == ST_OFF) || (state_q[c] == ST_CP_ON);
            pll_ready[c]   = (state_q[c] == ST_READY);
            pll_trim[c*TRIM_W +: TRIM_W] = trim_q[c];
        end
    end

    assign pll_bypass = bypass_q;
    assign spi_sdo    = sdo_q;
    assign spi_sdo_oe = sdo_oe_q;

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge ref_clk) begin
        if (!porb) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            sck_prev_q  <= 1'b0;
            bit_cnt_q   <= '0;
            shift_in_q  <= '0;
            wr_pend_q   <= 1'b0;
            rd_pend_q   <= 1'b0;
            rd_frame_q  <= 1'b0;
            shift_out_q <= '0;
            sdo_q       <= 1'b0;
            sdo_oe_q    <= 1'b0;
            // NOTE: the register file is a handful of flops, not a RAM, and
            // must read back 0 after reset, so it is reset with everything else.
            ctrl_q      <= '{default: '0};
            trim_reg_q  <= '{default: '0};
            dly_q       <= '{default: '0};
            state_q     <= '{default: ST_OFF};
            cnt_q       <= '{default: '0};
            trim_q      <= '{default: '0};
            bypass_q    <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            sck_prev_q  <= sck_prev_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_in_q  <= shift_in_d;
            wr_pend_q   <= wr_pend_d;
            rd_pend_q   <= rd_pend_d;
            rd_frame_q  <= rd_frame_d;
            shift_out_q <= shift_out_d;
            sdo_q       <= sdo_d;
            sdo_oe_q    <= sdo_oe_d;
            ctrl_q      <= ctrl_d;
            trim_reg_q  <= trim_reg_d;
            dly_q       <= dly_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            trim_q      <= trim_d;
            bypass_q    <= bypass_d;
        end
    end

endmodule

// File: tb/tb_pll_cfg_seq.sv
// -----------------------------------------------------------------------------
// tb_pll_cfg_seq
//
// Self-checking bench for pll_cfg_seq with the default parameters
// (2 channels, 4-bit trim, SETTLE = 64). SPI frames are driven at 1/16 of
// ref_clk. Expected read bytes and expected sequencer timing gaps go into
// scoreboard queues when the stimulus is issued, and are popped when the
// DUT produces the result. A negedge monitor timestamps every edge of the
// PLL control outputs so that sequencing can be checked in cycles.
// -----------------------------------------------------------------------------
module tb_pll_cfg_seq;

    localparam int N_PLL  = 2;
    localparam int TRIM_W = 4;
    localparam int SETTLE = 64;
    localparam int HALF   = 80;   // SCK half period in ns (ref_clk is 10 ns)

    logic                    ref_clk = 1'b0;
    logic                    porb    = 1'b0;
    logic                    spi_sck = 1'b0;
    logic                    spi_csb = 1'b1;
    logic                    spi_sdi = 1'b0;
    logic                    spi_sdo;
    logic                    spi_sdo_oe;
    logic [N_PLL-1:0]        pll_cp_enb;
    logic [N_PLL-1:0]        pll_vco_enb;
    logic [N_PLL-1:0]        pll_bypass;
    logic [N_PLL*TRIM_W-1:0] pll_trim;
    logic [N_PLL-1:0]        pll_ready;

    int checks   = 0;
    int failures = 0;

    logic [7:0] rd_exp_q [$];   // expected read bytes
    int         gap_exp_q[$];   // expected sequencer gaps in cycles

    pll_cfg_seq #(
        .N_PLL  (N_PLL),
        .TRIM_W (TRIM_W),
        .SETTLE (SETTLE),
        .ID_VAL (8'hA5)
    ) dut (
        .ref_clk     (ref_clk),
        .porb        (porb),
        .spi_sck     (spi_sck),
        .spi_csb     (spi_csb),
        .spi_sdi     (spi_sdi),
        .spi_sdo     (spi_sdo),
        .spi_sdo_oe  (spi_sdo_oe),
        .pll_cp_enb  (pll_cp_enb),
        .pll_vco_enb (pll_vco_enb),
        .pll_bypass  (pll_bypass),
        .pll_trim    (pll_trim),
        .pll_ready   (pll_ready)
    );

    always #5 ref_clk = ~ref_clk;

    // ---------------------------------------------------------------------
    // Edge monitor. Event kinds:
    //   0 cp fall, 1 vco fall, 2 ready rise, 3 cp rise, 4 vco rise,
    //   5 ready fall, 6 trim change
    // ---------------------------------------------------------------------
    int                      cyc = 0;
    int                      mark [7][N_PLL];
    logic [N_PLL-1:0]        cp_prev, vco_prev, rdy_prev;
    logic [N_PLL*TRIM_W-1:0] trim_prev;

    always @(negedge ref_clk) begin
        cyc++;
        for (int c = 0; c < N_PLL; c++) begin
            if (cp_prev[c]  === 1'b1 && pll_cp_enb[c]  === 1'b0) mark[0][c] = cyc;
            if (vco_prev[c] === 1'b1 && pll_vco_enb[c] === 1'b0) mark[1][c] = cyc;
            if (rdy_prev[c] === 1'b0 && pll_ready[c]   === 1'b1) mark[2][c] = cyc;
            if (cp_prev[c]  === 1'b0 && pll_cp_enb[c]  === 1'b1) mark[3][c] = cyc;
            if (vco_prev[c] === 1'b0 && pll_vco_enb[c] === 1'b1) mark[4][c] = cyc;
            if (rdy_prev[c] === 1'b1 && pll_ready[c]   === 1'b0) mark[5][c] = cyc;
            if (trim_prev[c*TRIM_W +: TRIM_W] !== pll_trim[c*TRIM_W +: TRIM_W] &&
                trim_prev[c*TRIM_W +: TRIM_W] !== 'x)
                mark[6][c] = cyc;
        end
        cp_prev   = pll_cp_enb;
        vco_prev  = pll_vco_enb;
        rdy_prev  = pll_ready;
        trim_prev = pll_trim;
    end

    task automatic clear_marks();
        for (int k = 0; k < 7; k++)
            for (int c = 0; c < N_PLL; c++)
                mark[k][c] = -1;
    endtask

    task automatic wait_mark(input string name, input int kind, input int ch, input int bound);
        int n = 0;
        while (mark[kind][ch] == -1 && n < bound) begin
            @(negedge ref_clk);
            n++;
        end
        if (mark[kind][ch] == -1) begin
            checks++;
            failures++;
            $display("FAIL %s: no event within %0d cycles", name, bound);
        end
    endtask

    // ---------------------------------------------------------------------
    // SPI master (mode 0). Bits past 16 are driven as 1. Read data is
    // sampled on rises 9..16, and oe_all records whether SDO_OE was high
    // at every one of those samples.
    // ---------------------------------------------------------------------
    task automatic spi_frame(input logic [15:0] frame, input int nbits,
                             output logic [7:0] rd, output logic oe_all);
        rd      = 8'h00;
        oe_all  = 1'b1;
        spi_csb = 1'b0;
        #(HALF);
        for (int i = 0; i < nbits; i++) begin
            spi_sdi = (i < 16) ? frame[15-i] : 1'b1;
            #(HALF);
            spi_sck = 1'b1;
            if (i >= 8 && i < 16) begin
                rd[15-i] = spi_sdo;
                if (spi_sdo_oe !== 1'b1) oe_all = 1'b0;
            end
            #(HALF);
            spi_sck = 1'b0;
        end
        #(HALF);
        spi_csb = 1'b1;
        spi_sdi = 1'b0;
        #(2*HALF);
    endtask

    task automatic spi_write(input logic [6:0] addr, input logic [7:0] data);
        logic [7:0] rd;
        logic       oe_all;
        spi_frame({1'b1, addr, data}, 16, rd, oe_all);
    endtask

    task automatic spi_read(input string name, input logic [6:0] addr, input logic [7:0] exp);
        logic [7:0] rd;
        logic [7:0] want;
        logic       oe_all;
        rd_exp_q.push_back(exp);
        spi_frame({1'b0, addr, 8'h00}, 16, rd, oe_all);
        want = rd_exp_q.pop_front();
        checks++;
        if (rd !== want) begin
            failures++;
            $display("FAIL %s: read 0x%02h, expected 0x%02h", name, rd, want);
        end
        checks++;
        if (oe_all !== 1'b1 || spi_sdo_oe !== 1'b0) begin
            failures++;
            $display("FAIL %s_oe: oe during data=%0b after csb=%0b, expected 1 and 0",
                     name, oe_all, spi_sdo_oe);
        end
    endtask

    // ---------------------------------------------------------------------
    // Scenarios
    // ---------------------------------------------------------------------
    task automatic test_reset();
        logic [17:0] obs;
        porb    = 1'b0;
        spi_csb = 1'b1;
        repeat (4) @(negedge ref_clk);
        obs = {pll_cp_enb, pll_vco_enb, pll_bypass, pll_trim, pll_ready, spi_sdo, spi_sdo_oe};
        checks++;
        if (obs !== {2'b11, 2'b11, 2'b00, 8'h00, 2'b00, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_outputs: got 0x%05h, expected 0x%05h", obs,
                     {2'b11, 2'b11, 2'b00, 8'h00, 2'b00, 1'b0, 1'b0});
        end
        porb = 1'b1;
        repeat (4) @(negedge ref_clk);
        spi_read("id_read", 7'h7F, 8'hA5);
        checks++;
        if (pll_cp_enb !== 2'b11 || pll_vco_enb !== 2'b11 || pll_trim !== 8'h00) begin
            failures++;
            $display("FAIL idle_after_id: cp=%b vco=%b trim=%h, expected 11 11 00",
                     pll_cp_enb, pll_vco_enb, pll_trim);
        end
    endtask

    task automatic test_seq_ch0();
        int want;
        spi_write(7'h02, 8'h05);
        spi_read("dly0_rb", 7'h02, 8'h05);
        clear_marks();
        gap_exp_q.push_back(6);
        gap_exp_q.push_back(SETTLE);
        spi_write(7'h00, 8'h01);
        wait_mark("ch0_ready", 2, 0, 300);
        want = gap_exp_q.pop_front();
        checks++;
        if (mark[0][0] == -1 || mark[1][0] - mark[0][0] != want) begin
            failures++;
            $display("FAIL ch0_cp_to_vco: gap %0d cycles, expected %0d",
                     mark[1][0] - mark[0][0], want);
        end
        want = gap_exp_q.pop_front();
        checks++;
        if (mark[1][0] == -1 || mark[2][0] - mark[1][0] != want) begin
            failures++;
            $display("FAIL ch0_vco_to_ready: gap %0d cycles, expected %0d",
                     mark[2][0] - mark[1][0], want);
        end
        checks++;
        if (pll_cp_enb[1] !== 1'b1 || pll_vco_enb[1] !== 1'b1 || mark[0][1] != -1) begin
            failures++;
            $display("FAIL ch1_idle: cp1=%b vco1=%b, expected 1 1", pll_cp_enb[1], pll_vco_enb[1]);
        end
        spi_read("status0_ready", 7'h03, 8'h07);
    endtask

    task automatic test_trim_shadow();
        spi_write(7'h01, 8'h0A);
        repeat (4) @(negedge ref_clk);
        checks++;
        if (pll_trim[3:0] !== 4'h0) begin
            failures++;
            $display("FAIL trim0_held: pll_trim[3:0]=%h, expected 0", pll_trim[3:0]);
        end
        spi_read("trim0_rb", 7'h01, 8'h0A);
        clear_marks();
        spi_write(7'h00, 8'h00);
        wait_mark("ch0_off", 3, 0, 50);
        checks++;
        if (mark[4][0] != mark[3][0] || mark[5][0] != mark[3][0]) begin
            failures++;
            $display("FAIL ch0_off_together: cp rise @%0d vco rise @%0d ready fall @%0d, expected equal",
                     mark[3][0], mark[4][0], mark[5][0]);
        end
        checks++;
        if (mark[6][0] != mark[3][0] + 1 || pll_trim[3:0] !== 4'hA) begin
            failures++;
            $display("FAIL trim0_apply: changed @%0d to %h, expected @%0d to a",
                     mark[6][0], pll_trim[3:0], mark[3][0] + 1);
        end
    endtask

    task automatic test_ch1_dly0();
        int want;
        spi_write(7'h05, 8'hF3);
        spi_read("trim1_unused_bits", 7'h05, 8'h03);
        checks++;
        if (pll_trim[7:4] !== 4'h3) begin
            failures++;
            $display("FAIL trim1_off_load: pll_trim[7:4]=%h, expected 3", pll_trim[7:4]);
        end
        spi_write(7'h06, 8'h00);
        clear_marks();
        gap_exp_q.push_back(1);
        gap_exp_q.push_back(SETTLE);
        spi_write(7'h04, 8'h03);
        wait_mark("ch1_ready", 2, 1, 300);
        want = gap_exp_q.pop_front();
        checks++;
        if (mark[0][1] == -1 || mark[1][1] - mark[0][1] != want) begin
            failures++;
            $display("FAIL ch1_dly0_cp_on: gap %0d cycles, expected %0d",
                     mark[1][1] - mark[0][1], want);
        end
        want = gap_exp_q.pop_front();
        checks++;
        if (mark[2][1] - mark[1][1] != want) begin
            failures++;
            $display("FAIL ch1_settle: gap %0d cycles, expected %0d",
                     mark[2][1] - mark[1][1], want);
        end
        checks++;
        if (mark[0][0] != -1 || pll_cp_enb[0] !== 1'b1 || pll_vco_enb[0] !== 1'b1 ||
            pll_ready[0] !== 1'b0 || pll_trim[3:0] !== 4'hA) begin
            failures++;
            $display("FAIL ch0_isolated: cp0=%b vco0=%b rdy0=%b trim0=%h, expected 1 1 0 a",
                     pll_cp_enb[0], pll_vco_enb[0], pll_ready[0], pll_trim[3:0]);
        end
        checks++;
        if (pll_bypass !== 2'b10) begin
            failures++;
            $display("FAIL bypass: pll_bypass=%b, expected 10", pll_bypass);
        end
        spi_read("ctrl1_rb", 7'h04, 8'h03);
    endtask

    task automatic test_frames();
        logic [7:0] rd;
        logic       oe_all;
        spi_frame({1'b1, 7'h02, 8'h33}, 12, rd, oe_all);
        spi_read("abort_dly0", 7'h02, 8'h05);
        spi_frame({1'b1, 7'h02, 8'h21}, 20, rd, oe_all);
        spi_read("long_dly0", 7'h02, 8'h21);
    endtask

    task automatic test_ro_unmapped();
        spi_write(7'h03, 8'hFF);
        spi_read("status0_ro", 7'h03, 8'h00);
        spi_write(7'h07, 8'h00);
        spi_read("status1_ro", 7'h07, 8'h07);
        spi_write(7'h10, 8'h5A);
        spi_read("unmapped", 7'h10, 8'h00);
    endtask

    task automatic test_reset_mid();
        logic [17:0] obs;
        clear_marks();
        spi_write(7'h00, 8'h01);
        wait_mark("ch0_vco_on", 1, 0, 200);
        repeat (3) @(negedge ref_clk);
        checks++;
        if (pll_vco_enb[0] !== 1'b0 || pll_ready[0] !== 1'b0) begin
            failures++;
            $display("FAIL ch0_in_vco_on: vco0=%b rdy0=%b, expected 0 0", pll_vco_enb[0], pll_ready[0]);
        end
        porb = 1'b0;
        @(negedge ref_clk);
        obs = {pll_cp_enb, pll_vco_enb, pll_bypass, pll_trim, pll_ready, spi_sdo, spi_sdo_oe};
        checks++;
        if (obs !== {2'b11, 2'b11, 2'b00, 8'h00, 2'b00, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_mid_outputs: got 0x%05h, expected 0x%05h", obs,
                     {2'b11, 2'b11, 2'b00, 8'h00, 2'b00, 1'b0, 1'b0});
        end
        porb = 1'b1;
        repeat (4) @(negedge ref_clk);
        spi_read("dly0_cleared", 7'h02, 8'h00);
        spi_read("ctrl1_cleared", 7'h04, 8'h00);
        spi_read("trim0_cleared", 7'h01, 8'h00);
        spi_read("status1_cleared", 7'h07, 8'h00);
    endtask

    initial begin
        clear_marks();
        test_reset();
        test_seq_ch0();
        test_trim_shadow();
        test_ch1_dly0();
        test_frames();
        test_ro_unmapped();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #800us;
        $display("FAIL watchdog: simulation did not finish within 800 us");
        $fatal(1, "watchdog expired");
    end

endmodule
